// File: rtl/seq_sum_accumulator.sv
// seq_sum_accumulator: streaming frame accumulator.
// Takes a frame of COUNT unsigned N-bit operands over a valid/ready input,
// sums them through a ripple adder and presents the total (and the number of
// operands in the frame) on a valid/ready output.
// Optional feature macro: ACCUM_EARLY_LAST_EN adds an in_last_i port that
// can close a frame before COUNT operands have arrived.

module n_bit_adder #(
  parameter int N = 16
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] sum_o
);

  logic carry_s;

  // Ripple the carry from bit 0 upward; the callers size N so the final carry is always zero.
  always_comb begin
    carry_s = 1'b0;
    sum_o   = '0;
    for (int i = 0; i < N; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ carry_s;
      carry_s  = (a_i[i] & b_i[i]) | (carry_s & (a_i[i] ^ b_i[i]));
    end
  end

endmodule

module seq_sum_accumulator #(
  parameter int N     = 16,
  parameter int COUNT = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid_i,
  output logic                              in_ready_o,
  input  logic [N-1:0]                      in_data_i,
`ifdef ACCUM_EARLY_LAST_EN
  input  logic                              in_last_i,
`endif
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic [N+$clog2(COUNT)-1:0]        out_sum_o,
  output logic [$clog2(COUNT+1)-1:0]        out_count_o
);

  // Sum width covers COUNT full-scale operands, so the total never wraps.
  localparam int ACC_W = N + $clog2(COUNT);
  localparam int CNT_W = $clog2(COUNT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_OUT   = 2'd2
  } state_e;

  state_e             state_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [ACC_W-1:0]   out_sum_q;
  logic [CNT_W-1:0]   out_count_q;

  logic [ACC_W-1:0]   acc_base_s;
  logic [ACC_W-1:0]   in_ext_s;
  logic [ACC_W-1:0]   acc_d;
  logic [CNT_W-1:0]   cnt_d;
  logic               frame_end_s;
  logic               in_beat_s;
  logic               out_beat_s;

  assign in_ext_s   = ACC_W'(in_data_i);
  assign in_beat_s  = in_valid_i & in_ready_q;
  assign out_beat_s = out_valid_q & out_ready_i;

  // First operand of a frame starts from zero; later ones add onto the running sum.
  always_comb begin
    if (state_q == S_ACCUM) begin
      acc_base_s = acc_q;
      cnt_d      = cnt_q + CNT_W'(1);
    end else begin
      acc_base_s = '0;
      cnt_d      = CNT_W'(1);
    end
  end

  n_bit_adder #(.N(ACC_W)) u_adder (
    .a_i   (acc_base_s),
    .b_i   (in_ext_s),
    .sum_o (acc_d)
  );

  // A frame closes on its COUNT-th operand, or earlier when the producer flags the last one.
  always_comb begin
    if (cnt_d == CNT_W'(COUNT)) begin
      frame_end_s = 1'b1;
    end
`ifdef ACCUM_EARLY_LAST_EN
    else if (in_last_i) begin
      frame_end_s = 1'b1;
    end
`endif
    else begin
      frame_end_s = 1'b0;
    end
  end

  // Frame FSM with registered handshake outputs and the held result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_ACCUM: begin
          if (in_beat_s) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            if (frame_end_s) begin
              state_q     <= S_OUT;
              out_sum_q   <= acc_d;
              out_count_q <= cnt_d;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= S_ACCUM;
            end
          end else begin
            state_q <= state_q;
          end
        end
        S_OUT: begin
          // Input is stalled here; the result stays put until the consumer takes it.
          if (out_beat_s) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end else begin
            state_q <= S_OUT;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          acc_q       <= '0;
          cnt_q       <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_sum_o   = out_sum_q;
  assign out_count_o = out_count_q;

endmodule

// File: tb/tb_seq_sum_accumulator.sv
// Self-checking bench for seq_sum_accumulator (N=16, COUNT=8).
// A reference model accumulates every accepted operand and pushes each frame
// total into a queue; every output handshake pops and compares it.

module tb_seq_sum_accumulator;

  localparam int N     = 16;
  localparam int COUNT = 8;
  localparam int ACC_W = N + $clog2(COUNT);
  localparam int CNT_W = $clog2(COUNT + 1);
`ifdef ACCUM_EARLY_LAST_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;

  exp_t             exp_q[$];
  logic [ACC_W-1:0] m_acc;
  int               m_cnt;
  int               n_checks;
  int               n_pass;

  seq_sum_accumulator #(.N(N), .COUNT(COUNT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
`ifdef ACCUM_EARLY_LAST_EN
    .in_last_i   (in_last),
`endif
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_sum_o   (out_sum),
    .out_count_o (out_count)
  );

  // 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Update the model with the handshakes the next edge will see, then advance one cycle.
  task automatic tick();
    exp_t e;
    if (!rst_n) begin
      m_acc = '0;
      m_cnt = 0;
      exp_q.delete();
    end else begin
      if (in_valid && in_ready) begin
        m_acc = m_acc + ACC_W'(in_data);
        m_cnt++;
        if (m_cnt == COUNT || (EARLY && in_last)) begin
          e.sum = m_acc;
          e.cnt = CNT_W'(m_cnt);
          exp_q.push_back(e);
          m_acc = '0;
          m_cnt = 0;
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_val("spurious_out", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_val("sb_sum", 32'(out_sum), 32'(e.sum));
          check_val("sb_count", 32'(out_count), 32'(e.cnt));
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [N-1:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Consume outstanding results with a bounded cycle budget.
  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      tick();
    end
    check_val("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    m_acc     = '0;
    m_cnt     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #2;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_out_sum", 32'(out_sum), 32'd0);
    check_val("rst_out_count", 32'(out_count), 32'd0);

    // 1: back-to-back 1..8, latency of one cycle after the last beat
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = N'(i);
      tick();
      if (i == 7) check_val("t1_valid_early", 32'(out_valid), 32'd0);
    end
    in_valid = 1'b0;
    check_val("t1_valid", 32'(out_valid), 32'd1);
    check_val("t1_ready_low", 32'(in_ready), 32'd0);
    check_val("t1_sum", 32'(out_sum), 32'd36);
    check_val("t1_count", 32'(out_count), 32'd8);
    drain();
    tick();
    check_val("t1_back_idle_v", 32'(out_valid), 32'd0);
    check_val("t1_back_idle_r", 32'(in_ready), 32'd1);

    // 2: full-scale operands, no wrap
    for (int i = 0; i < 8; i++) send(16'hFFFF, 1'b0);
    check_val("t2_sum", 32'(out_sum), 32'h7FFF8);
    drain();

    // 3: random bubbles between beats
    for (int i = 1; i <= 8; i++) begin
      int gaps;
      gaps = int'($urandom_range(0, 3));
      for (int g = 0; g < gaps; g++) begin
        tick();
        check_val("t3_ready", 32'(in_ready), 32'd1);
      end
      send(N'(i), 1'b0);
    end
    check_val("t3_sum", 32'(out_sum), 32'd36);
    drain();

    // 4: back-pressure on the output; pending input must not be consumed
    out_ready = 1'b0;
    for (int i = 10; i <= 17; i++) send(N'(i), 1'b0);
    in_valid = 1'b1;
    in_data  = 16'd99;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("t4_valid_hold", 32'(out_valid), 32'd1);
      check_val("t4_sum_hold", 32'(out_sum), 32'd108);
      check_val("t4_ready_low", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    drain();
    check_val("t4_release_v", 32'(out_valid), 32'd0);
    check_val("t4_release_r", 32'(in_ready), 32'd1);
    check_val("t4_sum_kept", 32'(out_sum), 32'd108);
    for (int i = 0; i < 8; i++) send(16'd3, 1'b0);
    check_val("t4_fresh_sum", 32'(out_sum), 32'd24);
    drain();

    // 5: reset mid-frame discards the partial sum
    for (int i = 0; i < 3; i++) send(16'd5, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_val("t5_rst_ready", 32'(in_ready), 32'd1);
    check_val("t5_rst_valid", 32'(out_valid), 32'd0);
    check_val("t5_rst_sum", 32'(out_sum), 32'd0);
    check_val("t5_rst_count", 32'(out_count), 32'd0);
    for (int i = 0; i < 8; i++) send(16'd2, 1'b0);
    check_val("t5_sum", 32'(out_sum), 32'd16);
    drain();

`ifdef ACCUM_EARLY_LAST_EN
    // 6: early termination with in_last, then a full frame without it
    send(16'd5, 1'b0);
    send(16'd6, 1'b0);
    send(16'd7, 1'b1);
    check_val("t6_valid", 32'(out_valid), 32'd1);
    check_val("t6_sum", 32'(out_sum), 32'd18);
    check_val("t6_count", 32'(out_count), 32'd3);
    drain();
    for (int i = 0; i < 8; i++) send(16'd1, 1'b0);
    check_val("t6_full_count", 32'(out_count), 32'd8);
    drain();
`endif

    tick();
    check_val("end_idle", 32'(out_valid), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
